// File: rtl/mips_bridge_pkg.sv
// Shared definitions for the MIPS Harvard-core to single-port memory bridge.
//   - default parameter constants for the bridge and its bus interface
//   - wait-counter width (large enough for timeouts up to 255 cycles)
//   - bridge FSM state encoding
package mips_bridge_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CNT_W   = 32;
    localparam int WAIT_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DATA   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERROR  = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/mips_mem_bridge_if.sv
// Single-port memory bus with waitrequest stalling.
//   master: address, read, write, writedata, byteenable out; waitrequest, readdata in
//   slave : the reverse
// A transfer completes in the first cycle a strobe is high and waitrequest is low;
// readdata is valid in that completing cycle.
interface mips_mem_bridge_if
    import mips_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/bridge_wait_timer.sv
// Counts consecutive stalled bus cycles and flags a timeout.
//   clk, reset : clock and synchronous active-high reset
//   clear      : return the count to zero (has priority over stall)
//   stall      : a strobe is high and waitrequest is high this cycle
//   timeout    : this is the TIMEOUT-th consecutive stalled cycle
module bridge_wait_timer
    import mips_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LAST_STALL = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (stall) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    // Flag on the cycle that brings the count to TIMEOUT while still stalled,
    // so the FSM leaves for ERROR at that same edge.
    assign timeout = stall && (count == LAST_STALL);

endmodule

// File: rtl/mips_mem_bridge.sv
// Bridges a Harvard MIPS core (separate fetch and data ports) onto one
// waitrequest-style memory bus, stepping the core with a clock enable.
//   clk, reset       : clock, synchronous active-high reset
//   core_*           : core activity in, one-cycle clock-enable pulse out
//   instr_*          : core fetch port; instr_readdata is the latched instruction
//   data_*, byte_enable : core load/store port; data_readdata is the latched load
//   bus              : master side of the shared memory bus
//   bus_error        : sticky flag, set when waitrequest outlasts TIMEOUT cycles
//   retired          : count of clock-enable pulses, wraps
//
// state  | meaning
// IDLE   | core inactive, no bus activity
// FETCH  | reading instruction word at instr_address
// DATA   | load or store at data_address (store wins if both requested)
// COMMIT | one-cycle core clock enable, retired count advanced
// ERROR  | bus timed out; strobes low, core frozen until reset
module mips_mem_bridge
    import mips_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                core_active,
    output logic                core_clk_enable,

    input  logic [ADDR_W-1:0]   instr_address,
    input  logic                instr_read,
    output logic [DATA_W-1:0]   instr_readdata,

    input  logic [ADDR_W-1:0]   data_address,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W-1:0]   data_writedata,
    input  logic [DATA_W/8-1:0] byte_enable,
    output logic [DATA_W-1:0]   data_readdata,

    mips_mem_bridge_if.master   bus,

    output logic                bus_error,
    output logic [CNT_W-1:0]    retired
);

    bridge_state_t state;

    logic rd_q;
    logic wr_q;
    logic stall;
    logic timeout;

    // The bridge fetches whenever the core is active, so the fetch strobe
    // itself carries no extra information.
    logic unused_instr_read;
    assign unused_instr_read = instr_read;

    // ------------------------------------------------------------------
    // Bus address/data path. The core is frozen while a transfer stalls,
    // but the first stalled cycle's values are captured anyway so the bus
    // stays stable no matter what the core inputs do during the stall.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   live_addr;
    logic [DATA_W/8-1:0] live_be;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;
    logic [DATA_W/8-1:0] hold_be;
    logic                hold_valid;

    assign live_addr = (state == ST_DATA) ? data_address : instr_address;
    assign live_be   = (state == ST_DATA) ? byte_enable  : '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
        end else if (stall) begin
            if (!hold_valid) begin
                hold_valid <= 1'b1;
                hold_addr  <= live_addr;
                hold_wdata <= data_writedata;
                hold_be    <= live_be;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign bus.address    = hold_valid ? hold_addr  : live_addr;
    assign bus.writedata  = hold_valid ? hold_wdata : data_writedata;
    assign bus.byteenable = hold_valid ? hold_be    : live_be;
    assign bus.read       = rd_q;
    assign bus.write      = wr_q;

    // ------------------------------------------------------------------
    // Wait timer. Every state change follows a non-stalled cycle (a
    // completion or a strobe-free cycle), so clearing on any non-stalled
    // cycle gives a count that starts from zero in each new state.
    // ------------------------------------------------------------------
    assign stall = (rd_q || wr_q) && bus.waitrequest;

    bridge_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!stall),
        .stall   (stall),
        .timeout (timeout)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered strobes and clock enable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            core_clk_enable <= 1'b0;
            bus_error       <= 1'b0;
            retired         <= '0;
            instr_readdata  <= '0;
            data_readdata   <= '0;
        end else begin
            core_clk_enable <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (core_active) begin
                        state <= ST_FETCH;
                        rd_q  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (timeout) begin
                        state     <= ST_ERROR;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (!bus.waitrequest) begin
                        instr_readdata <= bus.readdata;
                        if (data_write || data_read) begin
                            state <= ST_DATA;
                            wr_q  <= data_write;
                            rd_q  <= !data_write;
                        end else begin
                            state           <= ST_COMMIT;
                            rd_q            <= 1'b0;
                            core_clk_enable <= 1'b1;
                            retired         <= retired + CNT_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (timeout) begin
                        state     <= ST_ERROR;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (!bus.waitrequest) begin
                        if (rd_q) begin
                            data_readdata <= bus.readdata;
                        end
                        state           <= ST_COMMIT;
                        rd_q            <= 1'b0;
                        wr_q            <= 1'b0;
                        core_clk_enable <= 1'b1;
                        retired         <= retired + CNT_W'(1);
                    end
                end

                ST_COMMIT: begin
                    if (core_active) begin
                        state <= ST_FETCH;
                        rd_q  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_ERROR: begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_mem_bridge.md
MIPS_MEM_BRIDGE -- requirements
Module: mips_mem_bridge

Interface
REQ-001 Parameter ADDR_W, 32, bus and core address width.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter TIMEOUT, 16, maximum cycles waitrequest may stay high before an error is raised (range 1..255).
REQ-004 Parameter CNT_W, 32, width of the retired-instruction counter.
REQ-005 One clock; reset is synchronous and active-high (ports clk, reset).
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 core_active  in  1  active output of the Harvard core.
REQ-009 core_clk_enable  out  1  clock enable to the core; one-cycle pulse per retired instruction.
REQ-010 instr_address  in  ADDR_W  core fetch address.
REQ-011 instr_read  in  1  core fetch request.
REQ-012 instr_readdata  out  DATA_W  latched instruction word.
REQ-013 data_address  in  ADDR_W  core data address.
REQ-014 data_read, data_write  in  1 each  core data strobes.
REQ-015 data_writedata  in  DATA_W  core store data.
REQ-016 byte_enable  in  DATA_W/8  core byte lanes.
REQ-017 data_readdata  out  DATA_W  latched load data.
REQ-018 address  out  ADDR_W  bus address.
REQ-019 read, write  out  1 each  bus strobes.
REQ-020 writedata  out  DATA_W  bus store data.
REQ-021 byteenable  out  DATA_W/8  bus byte lanes.
REQ-022 waitrequest  in  1  bus stall; a transfer completes in the first cycle the strobe is high and waitrequest is low.
REQ-023 readdata  in  DATA_W  bus read data, valid in the completing cycle.
REQ-024 bus_error  out  1  sticky timeout flag.
REQ-025 retired  out  CNT_W  count of core_clk_enable pulses.

Function
REQ-026 The FSM SHALL have states IDLE, FETCH, DATA, COMMIT and ERROR.
REQ-027 IDLE -> FETCH when core_active=1; otherwise remain in IDLE with all bus strobes low.
REQ-028 FETCH: read=1, address=instr_address, byteenable all ones; on completion, latch readdata into instr_readdata and go to DATA if the decoded core strobes request a transfer, otherwise go to COMMIT.
REQ-029 DATA: address=data_address, byteenable=byte_enable, writedata=data_writedata; data_write has priority over data_read when both are high; on a read completion, latch readdata into data_readdata; then go to COMMIT.
REQ-030 COMMIT: core_clk_enable=1 for exactly one cycle and retired increments by 1 (wrapping modulo 2^CNT_W); next state is FETCH if core_active=1, otherwise IDLE.
REQ-031 Bus strobes, address, writedata and byteenable SHALL hold stable while waitrequest=1.
REQ-032 The wait counter SHALL clear on every state entry and increment each stalled cycle; when it reaches TIMEOUT with waitrequest still high: go to ERROR, set bus_error, drop all strobes.
REQ-033 ERROR SHALL be absorbing until reset; core_clk_enable=0 in ERROR.
REQ-034 Minimum latency with waitrequest=0: 2 cycles per non-memory instruction and 3 cycles per load or store.
REQ-035 instr_readdata and data_readdata SHALL hold their values outside the cycles in which they are latched.

Reset
REQ-036 On a clk edge with reset=1: state=IDLE; read=0, write=0, core_clk_enable=0, bus_error=0, retired=0, wait counter=0, instr_readdata=0, data_readdata=0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer; strobes are low from the cycle after the reset edge, with no commit.

Structure
REQ-038 Package mips_bridge_pkg SHALL hold the state enum and default parameter constants.
REQ-039 Sub-module bridge_wait_timer SHALL hold the wait counter, with clear and stall inputs and a timeout output.

Verification
REQ-040 waitrequest=0, instruction ADDU: FETCH, COMMIT; one core_clk_enable pulse in cycle 2 after IDLE exit; retired=1.
REQ-041 LW with readdata=32'hDEADBEEF and waitrequest high for 3 cycles in DATA: data_readdata=32'hDEADBEEF; commit in cycle 6.
REQ-042 SW to 32'h0000_1004 with byte_enable=4'b0011: write=1, address=32'h1004, byteenable=4'b0011 for exactly one completing cycle.
REQ-043 TIMEOUT=4, waitrequest held high in FETCH: bus_error=1 after 4 stalled cycles, strobes low, no further core_clk_enable until reset.
REQ-044 Reset asserted during a stalled DATA write: write=0 in the next cycle, retired=0, state IDLE.
REQ-045 core_active falls during COMMIT: FSM enters IDLE; no further bus strobes.
